alu_issue_stage: RTL and testbench

- Upstream issue/retire wrapper for the floating-point/logic ALU.
- Accepts operation requests {a, b, op, tag} on a valid/ready interface and buffers them in an input FIFO.
- Drives registered operands and opcode into the ALU, tracks in-flight operations through the ALU's registered latency, and captures each result into a credit-protected result FIFO. Results carry their tag and IEEE-754 class flags.
- The ALU has no stall input, so every issued operation is guaranteed result-FIFO space before issue.

---
 rtl/alu_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Issue/retire wrapper for a fixed-latency ALU. Buffers requests,
//            issues only when result space is reserved via credits, and
//            returns tagged results with IEEE-754 class flags.
// Revision : 1.0
// ============================================================================
module alu_issue_stage #(
    parameter int DEPTH     = 4,
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             out_nan,
    output logic             out_inf,
    output logic             out_zero,
    output logic             out_denorm
);

    localparam int c_in_aw  = $clog2(DEPTH);
    localparam int c_res_aw = $clog2(RES_DEPTH);
    localparam int c_cred_w = $clog2(RES_DEPTH + 1);

    localparam logic [c_in_aw:0]    c_in_full    = (c_in_aw + 1)'(DEPTH);
    localparam logic [c_cred_w-1:0] c_cred_init  = c_cred_w'(RES_DEPTH);
    localparam logic [2:0]          c_op_illegal = 3'b111;
    localparam logic [31:0]         c_forced_nan = 32'h7FC0_0000;

    // Input FIFO
    logic [31:0]        r_in_a   [DEPTH];
    logic [31:0]        r_in_b   [DEPTH];
    logic [2:0]         r_in_op  [DEPTH];
    logic [TAG_W-1:0]   r_in_tag [DEPTH];
    logic [c_in_aw-1:0] r_in_wr;
    logic [c_in_aw-1:0] r_in_rd;
    logic [c_in_aw:0]   r_in_cnt;

    // ALU drive registers and in-flight tracking
    logic [31:0]         r_alu_a;
    logic [31:0]         r_alu_b;
    logic [2:0]          r_alu_op;
    logic [ALU_LAT:0]    r_pv;
    logic [ALU_LAT:0]    r_perr;
    logic [TAG_W-1:0]    r_ptag [ALU_LAT+1];
    logic [c_cred_w-1:0] r_credits;

    // Result FIFO; flag word is {err, nan, inf, zero, denorm}
    logic [31:0]         r_res_word [RES_DEPTH];
    logic [TAG_W-1:0]    r_res_tag  [RES_DEPTH];
    logic [4:0]          r_res_flag [RES_DEPTH];
    logic [c_res_aw-1:0] r_res_wr;
    logic [c_res_aw-1:0] r_res_rd;
    logic [c_res_aw:0]   r_res_cnt;

    logic        w_push;
    logic        w_issue;
    logic        w_issue_err;
    logic        w_cap;
    logic        w_pop;
    logic [31:0] w_cap_word;
    logic        w_exp_max;
    logic        w_exp_zero;
    logic        w_frac_nz;
    logic [4:0]  w_cap_flag;

    assign in_ready    = !rst && (r_in_cnt != c_in_full);
    assign w_push      = in_valid && in_ready;
    // A credit reserves a result FIFO slot, since the ALU cannot be stalled
    assign w_issue     = (r_in_cnt != '0) && (r_credits != '0);
    assign w_issue_err = (r_in_op[r_in_rd] == c_op_illegal);
    assign w_cap       = r_pv[ALU_LAT];
    assign w_pop       = out_valid && out_ready;

    assign w_cap_word = r_perr[ALU_LAT] ? c_forced_nan : alu_result;
    assign w_exp_max  = &w_cap_word[30:23];
    assign w_exp_zero = ~|w_cap_word[30:23];
    assign w_frac_nz  = |w_cap_word[22:0];
    assign w_cap_flag = {r_perr[ALU_LAT],
                         w_exp_max  &  w_frac_nz,
                         w_exp_max  & ~w_frac_nz,
                         w_exp_zero & ~w_frac_nz,
                         w_exp_zero &  w_frac_nz};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_wr   <= '0;
            r_in_rd   <= '0;
            r_in_cnt  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_pv      <= '0;
            r_credits <= c_cred_init;
            r_res_wr  <= '0;
            r_res_rd  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_push) begin
                r_in_wr <= r_in_wr + 1'b1;
            end
            if (w_issue) begin
                r_in_rd  <= r_in_rd + 1'b1;
                r_alu_a  <= r_in_a[r_in_rd];
                r_alu_b  <= r_in_b[r_in_rd];
                r_alu_op <= r_in_op[r_in_rd];
            end
            r_in_cnt  <= r_in_cnt + {{c_in_aw{1'b0}}, w_push}
                                  - {{c_in_aw{1'b0}}, w_issue};
            r_credits <= r_credits + {{(c_cred_w-1){1'b0}}, w_pop}
                                   - {{(c_cred_w-1){1'b0}}, w_issue};
            r_pv      <= {r_pv[ALU_LAT-1:0], w_issue};
            if (w_cap) begin
                r_res_wr <= r_res_wr + 1'b1;
            end
            if (w_pop) begin
                r_res_rd <= r_res_rd + 1'b1;
            end
            r_res_cnt <= r_res_cnt + {{c_res_aw{1'b0}}, w_cap}
                                   - {{c_res_aw{1'b0}}, w_pop};
        end
    end

    // Payload storage: only meaningful where the qualifying valid state says so
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_in_a[r_in_wr]   <= in_a;
            r_in_b[r_in_wr]   <= in_b;
            r_in_op[r_in_wr]  <= in_op;
            r_in_tag[r_in_wr] <= in_tag;
        end
        r_perr    <= {r_perr[ALU_LAT-1:0], w_issue_err};
        r_ptag[0] <= r_in_tag[r_in_rd];
        for (int i = 1; i <= ALU_LAT; i++) begin
            r_ptag[i] <= r_ptag[i-1];
        end
        if (w_cap) begin
            r_res_word[r_res_wr] <= w_cap_word;
            r_res_tag[r_res_wr]  <= r_ptag[ALU_LAT];
            r_res_flag[r_res_wr] <= w_cap_flag;
        end
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;

    assign out_valid  = (r_res_cnt != '0);
    assign out_result = out_valid ? r_res_word[r_res_rd] : '0;
    assign out_tag    = out_valid ? r_res_tag[r_res_rd]  : '0;
    assign {out_err, out_nan, out_inf, out_zero, out_denorm} =
        out_valid ? r_res_flag[r_res_rd] : 5'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Self-checking bench for alu_issue_stage with an ALU model and a
//            queue-based reference of expected results in acceptance order.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_stage;

    localparam int DEPTH     = 4;
    localparam int RES_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam int ALU_LAT   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_op;
    logic [31:0]      alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             out_nan;
    logic             out_inf;
    logic             out_zero;
    logic             out_denorm;

    alu_issue_stage #(
        .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err),
        .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
        .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return ~a;
            default: return a ^ b;
        endcase
    endfunction

    // External ALU: registered result ALU_LAT cycles after its operands
    logic [31:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_op);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    typedef struct packed {
        logic [31:0]      word;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             nan;
        logic             inf;
        logic             zero;
        logic             den;
    } res_t;

    function automatic res_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic [TAG_W-1:0] tag);
        res_t r;
        logic [7:0]  e;
        logic [22:0] f;
        r.word = (op == 3'b111) ? 32'h7FC0_0000 : alu_fn(a, b, op);
        r.tag  = tag;
        r.err  = (op == 3'b111);
        e      = r.word[30:23];
        f      = r.word[22:0];
        r.nan  = (e == 8'd255) && (f != 23'd0);
        r.inf  = (e == 8'd255) && (f == 23'd0);
        r.zero = (e == 8'd0)   && (f == 23'd0);
        r.den  = (e == 8'd0)   && (f != 23'd0);
        return r;
    endfunction

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    res_t exp_q[$];
    res_t log_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, against the acceptance-ordered reference
    initial begin
        res_t got;
        res_t prev;
        res_t e;
        logic hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got.word = out_result;
            got.tag  = out_tag;
            got.err  = out_err;
            got.nan  = out_nan;
            got.inf  = out_inf;
            got.zero = out_zero;
            got.den  = out_denorm;
            if (rst) begin
                check("ready_in_reset", 64'(in_ready), 64'd0);
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_fields", 64'(got), 64'(prev));
                end
                check("no_stale_result", 64'(out_valid && exp_q.size() == 0), 64'd0);
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", 64'(got), 64'(e));
                    log_q.push_back(got);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(expect_of(in_a, in_b, in_op, in_tag));
                    n_acc++;
                end
                check("occupancy_bound", 64'(exp_q.size() <= DEPTH + RES_DEPTH), 64'd1);
                hold = out_valid && !out_ready;
                prev = got;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag);
        bit ok;
        ok = 1'b0;
        drive(a, b, op, tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            align();
        end
        check("send_accepted", 64'(ok), 64'd1);
        align();
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 500; k++) begin
            if (log_q.size() >= n) break;
            @(negedge clk);
        end
        check("results_arrived", 64'(log_q.size() >= n), 64'd1);
        align();
    endtask

    // Single request into an empty system: latency and literal result
    task automatic single_and(input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag, input logic [31:0] exp_word);
        drive(a, b, 3'b100, tag);
        @(negedge clk);
        check("single_accept_ready", 64'(in_ready), 64'd1);
        align();
        in_valid = 1'b0;
        for (int k = 0; k <= ALU_LAT + 2; k++) begin
            @(negedge clk);
            check("single_latency", 64'(out_valid), 64'(k >= ALU_LAT + 2));
        end
        check("single_word", 64'(out_result), 64'(exp_word));
        check("single_tag", 64'(out_tag), 64'(tag));
        check("single_err_flags",
              64'({out_err, out_nan, out_inf, out_zero, out_denorm}), 64'd0);
        align();
    endtask

    initial begin
        int  acc;
        int  start;
        int  r;
        bit  took;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_fields",
              64'({out_result, out_tag, out_err, out_nan, out_inf, out_zero, out_denorm}), 64'd0);
        check("reset_alu_regs", 64'({alu_a, alu_op}), 64'd0);
        check("reset_alu_b", 64'(alu_b), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        align();

        single_and(32'hFFFF_0000, 32'h0F0F_0F0F, 4'd5, 32'h0F0F_0000);

        // Illegal opcode between two legal ones
        log_q.delete();
        send(32'h1234_5678, 32'h0000_FFFF, 3'b100, 4'd2);
        send(32'h0000_0000, 32'h0000_0000, 3'b111, 4'd3);
        send(32'h00F0_0000, 32'h0F00_0000, 3'b101, 4'd4);
        in_valid = 1'b0;
        wait_log(3);
        check("illegal_prev_word", 64'(log_q[0].word), 64'h0000_5678);
        check("illegal_prev_tag", 64'(log_q[0].tag), 64'd2);
        check("illegal_word", 64'(log_q[1].word), 64'h7FC0_0000);
        check("illegal_err_nan", 64'({log_q[1].err, log_q[1].nan, log_q[1].tag}), 64'({2'b11, 4'd3}));
        check("illegal_next_word", 64'(log_q[2].word), 64'h0FF0_0000);
        check("illegal_next_tag", 64'(log_q[2].tag), 64'd4);

        // Backpressure: 4 results held + 4 queued, nothing more accepted
        log_q.delete();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc < 10) drive($urandom, $urandom, 3'b101, TAG_W'(acc));
            else in_valid = 1'b0;
            @(negedge clk);
            took = in_valid && in_ready;
            align();
            if (took) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd8);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        align();
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            check("bp_drain_tag", 64'(out_tag), 64'(j));
        end
        align();
        send($urandom, $urandom, 3'b101, 4'd8);
        send($urandom, $urandom, 3'b101, 4'd9);
        in_valid = 1'b0;
        wait_log(10);
        check("bp_tail_tags", 64'({log_q[8].tag, log_q[9].tag}), 64'({4'd8, 4'd9}));

        // Class flags
        log_q.delete();
        send(32'h8000_0000, 32'h0000_0000, 3'b110, 4'd10);
        send(32'h7F80_0000, 32'hFF80_0000, 3'b100, 4'd11);
        send(32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 4'd12);
        send(32'h0000_0000, 32'hDEAD_BEEF, 3'b100, 4'd13);
        in_valid = 1'b0;
        wait_log(4);
        check("not_word", 64'(log_q[0].word), 64'h7FFF_FFFF);
        check("not_flags", 64'({log_q[0].err, log_q[0].nan, log_q[0].inf, log_q[0].zero, log_q[0].den}), 64'b01000);
        check("inf_word", 64'(log_q[1].word), 64'h7F80_0000);
        check("inf_flags", 64'({log_q[1].err, log_q[1].nan, log_q[1].inf, log_q[1].zero, log_q[1].den}), 64'b00100);
        check("denorm_flags", 64'({log_q[2].err, log_q[2].nan, log_q[2].inf, log_q[2].zero, log_q[2].den}), 64'b00001);
        check("zero_flags", 64'({log_q[3].err, log_q[3].nan, log_q[3].inf, log_q[3].zero, log_q[3].den}), 64'b00010);

        // Reset with work queued and in flight
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) send($urandom, $urandom, 3'b100, TAG_W'(j));
        in_valid = 1'b0;
        rst = 1'b1;
        align();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_alu_a", 64'(alu_a), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        end
        align();
        single_and(32'hA5A5_A5A5, 32'h0FF0_0FF0, 4'd7, 32'h05A0_05A0);

        // Random traffic with valid/ready toggling
        start = n_acc;
        for (int c = 0; c < 20000 && n_acc < start + 1000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = $urandom;
            in_b     = $urandom;
            r        = $urandom_range(0, 19);
            in_op    = (r < 6) ? 3'b100 : (r < 12) ? 3'b101 : (r < 19) ? 3'b110 : 3'b111;
            in_tag   = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            align();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_accept_count", 64'(n_acc - start >= 1000), 64'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
